// File: rtl/mar_burst.sv
// mar_burst: memory address register with strided, optionally windowed burst address generator
module mar_burst #(
  parameter int ADDR_W   = 13,
  parameter int LEN_W    = 4,
  parameter int STRIDE_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mar_write_en,
  input  logic [ADDR_W-1:0]   mar_in,
  input  logic                mar_read_en,
  output logic [ADDR_W-1:0]   mar_out,
  output logic [ADDR_W-1:0]   mar_cur,
  input  logic                burst_start,
  input  logic [LEN_W-1:0]    burst_len,
  input  logic [STRIDE_W-1:0] stride,
  input  logic                wrap_en,
  input  logic [ADDR_W-1:0]   wrap_base,
  input  logic [ADDR_W-1:0]   wrap_limit,
  output logic [ADDR_W-1:0]   addr_out,
  output logic                addr_valid,
  input  logic                addr_ready,
  output logic                busy,
  output logic                done
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]          state;
  logic [ADDR_W-1:0]   mar;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   limit_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    cnt;
  logic [STRIDE_W-1:0] stride_q;
  logic                wrap_q;
  logic [ADDR_W:0]     sum;
  logic [ADDR_W-1:0]   nxt;

  // Next beat address: one extra bit on the sum so a window limit near the top of the space still compares correctly
  always_comb begin
    sum = {1'b0, mar} + {{(ADDR_W + 1 - STRIDE_W){1'b0}}, stride_q};
    nxt = (wrap_q && sum > {1'b0, limit_q}) ? base_q : sum[ADDR_W-1:0];
  end

  // MAR, snapshot register and the IDLE/ISSUE/DONE sequencer
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      mar      <= '0;
      mar_out  <= '0;
      cnt      <= '0;
      len_q    <= '0;
      stride_q <= '0;
      wrap_q   <= 1'b0;
      base_q   <= '0;
      limit_q  <= '0;
    end else begin
      if (mar_read_en) mar_out <= mar;
      case (state)
        IDLE: begin
          if (mar_write_en) mar <= mar_in;
          if (burst_start) begin
            len_q    <= burst_len;
            stride_q <= stride;
            wrap_q   <= wrap_en;
            base_q   <= wrap_base;
            limit_q  <= wrap_limit;
            cnt      <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: if (addr_ready) begin
          mar <= nxt;
          cnt <= cnt + 1'b1;
          if (cnt == len_q) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mar_cur    = mar;
  assign addr_valid = state == ISSUE;
  assign addr_out   = addr_valid ? mar : '0;
  assign busy       = state != IDLE;
  assign done       = state == DONE;
endmodule

// File: tb/tb_mar_burst.sv
// tb_mar_burst: randomized and directed checks of mar_burst against a transaction-level address-list model
module tb_mar_burst;
  logic        clk = 1'b0;
  logic        rst;
  logic        mar_write_en, mar_read_en, burst_start, wrap_en, addr_ready;
  logic [12:0] mar_in, wrap_base, wrap_limit;
  logic [3:0]  burst_len, stride;
  logic [12:0] mar_out, mar_cur, addr_out;
  logic        addr_valid, busy, done;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  // model: phase 0 idle, 1 issuing, 2 done
  int          phase = 0;
  logic [12:0] m_mar = '0;
  logic [12:0] m_out = '0;
  logic [12:0] fin = '0;
  logic [12:0] q[$];
  logic [12:0] seen[$];
  logic [12:0] exp_q[$];

  mar_burst dut (
    .clk(clk), .rst(rst),
    .mar_write_en(mar_write_en), .mar_in(mar_in),
    .mar_read_en(mar_read_en), .mar_out(mar_out), .mar_cur(mar_cur),
    .burst_start(burst_start), .burst_len(burst_len), .stride(stride),
    .wrap_en(wrap_en), .wrap_base(wrap_base), .wrap_limit(wrap_limit),
    .addr_out(addr_out), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] nxt_addr(input int a, input int s, input logic w, input int b, input int l);
    int sum;
    sum = a + s;
    if (w) return (sum > l) ? 13'(b) : 13'(sum);
    return 13'(sum % 8192);
  endfunction

  // Called at a negedge with this cycle's inputs driven: check outputs, advance the model, cross one posedge
  task automatic cycle();
    logic [12:0] a;
    chk("addr_valid", addr_valid, phase == 1);
    chk("addr_out", addr_out, phase == 1 ? q[0] : 13'h0);
    chk("busy", busy, phase != 0);
    chk("done", done, phase == 2);
    chk("mar_cur", mar_cur, m_mar);
    chk("mar_out", mar_out, m_out);
    if (done) done_cnt++;
    if (addr_valid && addr_ready) seen.push_back(addr_out);
    if (!rst) begin
      phase = 0; m_mar = '0; m_out = '0; q.delete();
    end else begin
      if (mar_read_en) m_out = m_mar;
      if (phase == 0) begin
        if (mar_write_en) m_mar = mar_in;
        if (burst_start) begin
          a = m_mar;
          q.delete();
          for (int i = 0; i <= int'(burst_len); i++) begin
            q.push_back(a);
            a = nxt_addr(a, stride, wrap_en, wrap_base, wrap_limit);
          end
          fin = a;
          phase = 1;
        end
      end else if (phase == 1) begin
        if (addr_ready) begin
          void'(q.pop_front());
          if (q.size() == 0) begin
            m_mar = fin; phase = 2;
          end else m_mar = q[0];
        end
      end else phase = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, "_beats"}, seen.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < seen.size()) chk(tag, seen[i], exp_q[i]);
  endtask

  task automatic quiet();
    rst = 1'b1; mar_write_en = 0; mar_read_en = 0; burst_start = 0; wrap_en = 0;
    addr_ready = 1'b1; mar_in = '0; burst_len = '0; stride = '0; wrap_base = '0; wrap_limit = '0;
  endtask

  task automatic start(input logic [3:0] l, input logic [3:0] s, input logic w, input logic [12:0] b, input logic [12:0] lim);
    burst_start = 1'b1; burst_len = l; stride = s; wrap_en = w; wrap_base = b; wrap_limit = lim;
  endtask

  task automatic load(input logic [12:0] v);
    quiet(); mar_write_en = 1'b1; mar_in = v; cycle(); quiet();
  endtask

  initial begin
    // reset with random inputs
    rst = 1'b0;
    mar_write_en = 1'b1; mar_read_en = 1'b1; burst_start = 1'b1; addr_ready = 1'b1;
    mar_in = 13'($urandom); burst_len = 4'($urandom); stride = 4'($urandom);
    wrap_en = 1'($urandom); wrap_base = 13'($urandom); wrap_limit = 13'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mar_out", mar_out, 0);
    chk("rst_mar_cur", mar_cur, 0);
    chk("rst_valid", addr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // basic burst
    load(13'h100);
    start(3, 1, 0, 0, 0); cycle(); quiet();
    seen.delete(); done_cnt = 0;
    repeat (6) cycle();
    exp_q = '{13'h100, 13'h101, 13'h102, 13'h103};
    chk_seq("basic");
    chk("basic_done_pulses", done_cnt, 1);
    chk("basic_mar_cur", mar_cur, 13'h104);
    mar_read_en = 1'b1; cycle(); quiet();
    chk("basic_mar_out", mar_out, 13'h104);

    // backpressure on beat 1
    load(13'h100);
    start(3, 1, 0, 0, 0); cycle(); quiet();
    seen.delete(); done_cnt = 0;
    cycle();
    addr_ready = 1'b0; cycle();
    chk("bp_hold_addr", addr_out, 13'h101);
    chk("bp_hold_valid", addr_valid, 1);
    cycle();
    addr_ready = 1'b1;
    repeat (5) cycle();
    exp_q = '{13'h100, 13'h101, 13'h102, 13'h103};
    chk_seq("bp");
    chk("bp_done_pulses", done_cnt, 1);

    // window wrap
    load(13'h012);
    start(3, 1, 1, 13'h010, 13'h013); cycle(); quiet();
    seen.delete();
    repeat (6) cycle();
    exp_q = '{13'h012, 13'h013, 13'h010, 13'h011};
    chk_seq("wrap");
    chk("wrap_mar_cur", mar_cur, 13'h012);

    // overflow without wrap
    load(13'h1FFE);
    start(1, 2, 0, 0, 0); cycle(); quiet();
    seen.delete();
    repeat (4) cycle();
    exp_q = '{13'h1FFE, 13'h0000};
    chk_seq("ovf");
    chk("ovf_mar_cur", mar_cur, 13'h0002);

    // write+start together, then write and start ignored while busy
    quiet(); mar_write_en = 1'b1; mar_in = 13'h200; start(1, 1, 0, 0, 0);
    seen.delete(); cycle();
    mar_in = 13'h555; start(5, 3, 0, 0, 0); cycle(); quiet();
    repeat (4) cycle();
    exp_q = '{13'h200, 13'h201};
    chk_seq("coll");
    chk("coll_mar_cur", mar_cur, 13'h202);

    // reset mid-burst
    load(13'h040);
    start(7, 1, 0, 0, 0); cycle(); quiet();
    repeat (2) cycle();
    rst = 1'b0; cycle(); quiet();
    chk("mid_rst_valid", addr_valid, 0);
    chk("mid_rst_mar_cur", mar_cur, 0);
    chk("mid_rst_busy", busy, 0);
    start(1, 1, 0, 0, 0); cycle(); quiet();
    seen.delete();
    repeat (4) cycle();
    exp_q = '{13'h000, 13'h001};
    chk_seq("post_rst");

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom % 64) != 0;
      mar_write_en = ($urandom % 4) == 0;
      mar_in       = ($urandom % 2) ? 13'($urandom) : 13'($urandom % 64);
      mar_read_en  = 1'($urandom);
      burst_start  = ($urandom % 3) == 0;
      burst_len    = 4'($urandom);
      stride       = 4'($urandom);
      wrap_en      = 1'($urandom);
      wrap_base    = ($urandom % 2) ? 13'($urandom) : 13'($urandom % 32);
      wrap_limit   = wrap_base + 13'($urandom % 64);
      addr_ready   = ($urandom % 10) < 7;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
